// File: rtl/ntt_ctrl_if.sv
// ntt_ctrl_if: bundle between an NTT host/datapath and the ntt_ctrl sequencer.
//   master : host side, drives start_i/mode_i/red_i and observes everything else
//   slave  : ntt_ctrl side, drives status, RAM/ROM read port, butterfly selects,
//            write-back port and the current stage index
interface ntt_ctrl_if #(
  parameter int N_LOG2 = 8
) ();
  localparam int SW = $clog2(N_LOG2) + 1;

  logic              start_i;
  logic              mode_i;
  logic              red_i;
  logic              busy_o;
  logic              done_o;
  logic              rd_en_o;
  logic [N_LOG2-1:0] rd_addr_a_o;
  logic [N_LOG2-1:0] rd_addr_b_o;
  logic [N_LOG2-1:0] tw_addr_o;
  logic              sel_butterfly_o;
  logic              sel_red_o;
  logic              wr_en_o;
  logic [N_LOG2-1:0] wr_addr_a_o;
  logic [N_LOG2-1:0] wr_addr_b_o;
  logic [SW-1:0]     stage_o;

  modport master (
    output start_i, mode_i, red_i,
    input  busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o,
           stage_o
  );

  modport slave (
    input  start_i, mode_i, red_i,
    output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, tw_addr_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o,
           stage_o
  );
endinterface

// File: rtl/ntt_ctrl.sv
// ntt_ctrl: sequencer for an in-place forward (CT) / inverse (GS) NTT over
// N = 2**N_LOG2 coefficients. Issues one butterfly per cycle (coefficient pair
// a/b plus twiddle index), then replays each pair as a write-back address
// PIPE_LAT cycles later. A PIPE_LAT-cycle drain separates consecutive stages so
// that no stage reads a coefficient before the previous stage has written it.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : synchronous active-high reset
//   bus    : ntt_ctrl_if.slave (start/mode/red in; busy/done, read port,
//            twiddle index, butterfly selects, write port, stage index out)
module ntt_ctrl #(
  parameter int N_LOG2 = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ntt_ctrl_if.slave    bus
);
  localparam int PIPE_LAT = RD_LAT + BF_LAT;
  localparam int SW       = $clog2(N_LOG2) + 1;
  localparam int IW       = N_LOG2 - 1;
  localparam int DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [IW-1:0]   I_LAST = '1;
  localparam logic [IW-1:0]   I_ONE  = IW'(1);
  localparam logic [SW-1:0]   S_LAST = SW'(N_LOG2 - 1);
  localparam logic [SW-1:0]   S_ONE  = SW'(1);
  localparam logic [DW-1:0]   D_LAST = DW'(PIPE_LAT - 1);
  localparam logic [DW-1:0]   D_ONE  = DW'(1);
  localparam logic [N_LOG2:0] N_FULL = {1'b1, {N_LOG2{1'b0}}};
  localparam logic [N_LOG2:0] W_ONE  = (N_LOG2 + 1)'(1);
  localparam logic [N_LOG2-1:0] A_ONE = N_LOG2'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic          mode_q, mode_d;
  logic          red_q, red_d;
  logic [SW-1:0] s_q, s_d;
  logic [IW-1:0] i_q, i_d;
  logic [DW-1:0] d_q, d_d;

  // Control FSM: i walks the N/2 butterflies of stage s, d counts drain cycles
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    red_d   = red_q;
    s_d     = s_q;
    i_d     = i_q;
    d_d     = d_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          mode_d  = bus.mode_i;
          red_d   = bus.red_i;
          s_d     = '0;
          i_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        i_d = i_q + I_ONE;
        if (i_q == I_LAST) begin
          i_d     = '0;
          d_d     = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        d_d = d_q + D_ONE;
        if (d_q == D_LAST) begin
          if (s_q == S_LAST) begin
            state_d = DONE;
          end else begin
            s_d     = s_q + S_ONE;
            i_d     = '0;
            state_d = RUN;
          end
        end
      end
      DONE: begin
        s_d     = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      red_q   <= 1'b0;
      s_q     <= '0;
      i_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      red_q   <= red_d;
      s_q     <= s_d;
      i_q     <= i_d;
      d_q     <= d_d;
    end
  end

  // Address generation. len is always a power of two, so i/len and i%len are
  // a shift and a mask by sh = log2(len); bit sh of a is zero, so b = a | len.
  logic              run;
  logic [SW-1:0]     sh;
  logic [N_LOG2-1:0] len, grp, ofs, addr_a, addr_b, tw;

  always_comb begin
    run    = (state_q == RUN);
    sh     = mode_q ? s_q : (S_LAST - s_q);
    len    = A_ONE << sh;
    ofs    = {1'b0, i_q} & (len - A_ONE);
    grp    = {1'b0, i_q} >> sh;
    addr_a = ((grp << sh) << 1) | ofs;
    addr_b = addr_a | len;
    if (mode_q) tw = N_LOG2'((N_FULL >> s_q) - {1'b0, grp} - W_ONE);
    else        tw = (A_ONE << s_q) + grp;
  end

  // Write-back delay line {en, a, b}; shifts every cycle regardless of state
  logic              en_pipe_q [PIPE_LAT];
  logic              en_pipe_d [PIPE_LAT];
  logic [N_LOG2-1:0] a_pipe_q  [PIPE_LAT];
  logic [N_LOG2-1:0] a_pipe_d  [PIPE_LAT];
  logic [N_LOG2-1:0] b_pipe_q  [PIPE_LAT];
  logic [N_LOG2-1:0] b_pipe_d  [PIPE_LAT];

  always_comb begin
    en_pipe_d    = en_pipe_q;
    a_pipe_d     = a_pipe_q;
    b_pipe_d     = b_pipe_q;
    en_pipe_d[0] = run;
    a_pipe_d[0]  = run ? addr_a : '0;
    b_pipe_d[0]  = run ? addr_b : '0;
    for (int unsigned j = 1; j < PIPE_LAT; j++) begin
      en_pipe_d[j] = en_pipe_q[j-1];
      a_pipe_d[j]  = a_pipe_q[j-1];
      b_pipe_d[j]  = b_pipe_q[j-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned j = 0; j < PIPE_LAT; j++) begin
        en_pipe_q[j] <= 1'b0;
        a_pipe_q[j]  <= '0;
        b_pipe_q[j]  <= '0;
      end
    end else begin
      en_pipe_q <= en_pipe_d;
      a_pipe_q  <= a_pipe_d;
      b_pipe_q  <= b_pipe_d;
    end
  end

  assign bus.busy_o          = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done_o          = (state_q == DONE);
  assign bus.rd_en_o         = run;
  assign bus.rd_addr_a_o     = run ? addr_a : '0;
  assign bus.rd_addr_b_o     = run ? addr_b : '0;
  assign bus.tw_addr_o       = run ? tw : '0;
  assign bus.sel_butterfly_o = mode_q;
  assign bus.sel_red_o       = red_q;
  assign bus.wr_en_o         = en_pipe_q[PIPE_LAT-1];
  assign bus.wr_addr_a_o     = a_pipe_q[PIPE_LAT-1];
  assign bus.wr_addr_b_o     = b_pipe_q[PIPE_LAT-1];
  assign bus.stage_o         = s_q;
endmodule

// File: tb/tb_ntt_ctrl.sv
// tb_ntt_ctrl: runs two sequencers side by side (N=256, RD_LAT=1, BF_LAT=1 and
// N=8, RD_LAT=2, BF_LAT=0) under random start/mode/red traffic. Each accepted
// start expands into the full list of expected reads, writes and the done
// cycle, computed from the NTT index rules with plain division/modulo; a
// negedge monitor pops and compares whenever the DUT presents an output.
module tb_ntt_ctrl;
  localparam int BIG_L = 8;
  localparam int BIG_RD = 1;
  localparam int BIG_BF = 1;
  localparam int SML_L = 3;
  localparam int SML_RD = 2;
  localparam int SML_BF = 0;

  typedef struct {
    int unsigned cyc, a, b, k, s;
    bit m, r;
  } rd_exp_t;

  typedef struct {
    int unsigned cyc, a, b;
  } wr_exp_t;

  typedef struct {
    bit busy, done, rd_en, sb, sr, wr_en;
    int unsigned ra, rb, tw, wa, wb, stage;
  } snap_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ntt_ctrl_if #(.N_LOG2(BIG_L)) if_big ();
  ntt_ctrl_if #(.N_LOG2(SML_L)) if_sml ();

  ntt_ctrl #(.N_LOG2(BIG_L), .RD_LAT(BIG_RD), .BF_LAT(BIG_BF)) u_big (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_big)
  );

  ntt_ctrl #(.N_LOG2(SML_L), .RD_LAT(SML_RD), .BF_LAT(SML_BF)) u_sml (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (if_sml)
  );

  rd_exp_t     rd_q   [2][$];
  wr_exp_t     wr_q   [2][$];
  int unsigned done_q [2][$];
  int unsigned last_done [2];
  int unsigned busy_lo [2] = '{1, 1};
  int unsigned busy_hi [2] = '{0, 0};
  int unsigned cur_t0  [2];
  int unsigned runs    [2] = '{0, 0};
  int unsigned zero_chk_cyc = 0;
  bit          zero_chk_en  = 0;
  bit          mon_en       = 0;
  bit          rst_done     = 0;
  int          n_checks     = 0;
  int          n_errors     = 0;

  task automatic check(input bit ok, input string name, input string detail);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic snap_t get_snap(input int u);
    snap_t sn;
    if (u == 0) begin
      sn.busy = if_big.busy_o;   sn.done = if_big.done_o;   sn.rd_en = if_big.rd_en_o;
      sn.sb = if_big.sel_butterfly_o; sn.sr = if_big.sel_red_o; sn.wr_en = if_big.wr_en_o;
      sn.ra = 32'(if_big.rd_addr_a_o); sn.rb = 32'(if_big.rd_addr_b_o);
      sn.tw = 32'(if_big.tw_addr_o);   sn.wa = 32'(if_big.wr_addr_a_o);
      sn.wb = 32'(if_big.wr_addr_b_o); sn.stage = 32'(if_big.stage_o);
    end else begin
      sn.busy = if_sml.busy_o;   sn.done = if_sml.done_o;   sn.rd_en = if_sml.rd_en_o;
      sn.sb = if_sml.sel_butterfly_o; sn.sr = if_sml.sel_red_o; sn.wr_en = if_sml.wr_en_o;
      sn.ra = 32'(if_sml.rd_addr_a_o); sn.rb = 32'(if_sml.rd_addr_b_o);
      sn.tw = 32'(if_sml.tw_addr_o);   sn.wa = 32'(if_sml.wr_addr_a_o);
      sn.wb = 32'(if_sml.wr_addr_b_o); sn.stage = 32'(if_sml.stage_o);
    end
    return sn;
  endfunction

  function automatic bit is_zero(input snap_t sn);
    return !(sn.busy | sn.done | sn.rd_en | sn.sb | sn.sr | sn.wr_en) &&
           sn.ra == 0 && sn.rb == 0 && sn.tw == 0 && sn.wa == 0 &&
           sn.wb == 0 && sn.stage == 0;
  endfunction

  // Reference model: expand one accepted start (edge after cycle t0) into
  // every read, write and the done pulse the run must produce.
  function automatic void model_run(input int u, input int unsigned t0,
                                    input bit m, input bit r);
    int unsigned lg   = (u == 0) ? BIG_L : SML_L;
    int unsigned plat = (u == 0) ? (BIG_RD + BIG_BF) : (SML_RD + SML_BF);
    int unsigned n    = 1 << lg;
    int unsigned half = n / 2;
    int unsigned dn   = t0 + 1 + lg * (half + plat);
    for (int unsigned s = 0; s < lg; s++) begin
      for (int unsigned i = 0; i < half; i++) begin
        rd_exp_t re;
        wr_exp_t we;
        int unsigned len = m ? (1 << s) : (n >> (s + 1));
        int unsigned g   = i / len;
        re.cyc = t0 + 1 + s * (half + plat) + i;
        re.a   = g * 2 * len + (i % len);
        re.b   = re.a + len;
        re.k   = m ? ((n >> s) - 1 - g) : ((1 << s) + g);
        re.s   = s;
        re.m   = m;
        re.r   = r;
        rd_q[u].push_back(re);
        we.cyc = re.cyc + plat;
        we.a   = re.a;
        we.b   = re.b;
        wr_q[u].push_back(we);
      end
    end
    done_q[u].push_back(dn);
    last_done[u] = dn;
    busy_lo[u]   = t0 + 1;
    busy_hi[u]   = dn - 1;
    cur_t0[u]    = t0;
    runs[u]      = runs[u] + 1;
  endfunction

  // Reset during cycle c: nothing the aborted run would produce after c survives
  function automatic void flush(input int u, input int unsigned c);
    while (rd_q[u].size() > 0 && rd_q[u][rd_q[u].size()-1].cyc > c)
      rd_q[u].delete(rd_q[u].size() - 1);
    while (wr_q[u].size() > 0 && wr_q[u][wr_q[u].size()-1].cyc > c)
      wr_q[u].delete(wr_q[u].size() - 1);
    while (done_q[u].size() > 0 && done_q[u][done_q[u].size()-1] > c)
      done_q[u].delete(done_q[u].size() - 1);
    if (busy_hi[u] > c) busy_hi[u] = c;
    if (last_done[u] > c) last_done[u] = c;
  endfunction

  task automatic mon_unit(input int u);
    snap_t sn;
    int unsigned c;
    sn = get_snap(u);
    c  = cyc;
    if (sn.rd_en) begin
      if (rd_q[u].size() == 0) begin
        check(1'b0, $sformatf("rd_unexpected_u%0d", u),
              $sformatf("cyc %0d got read a=%0d b=%0d k=%0d, required no read", c, sn.ra, sn.rb, sn.tw));
      end else begin
        rd_exp_t e;
        e = rd_q[u].pop_front();
        check(c == e.cyc && sn.ra == e.a && sn.rb == e.b && sn.tw == e.k &&
              sn.stage == e.s && sn.sb == e.m && sn.sr == e.r,
              $sformatf("rd_u%0d", u),
              $sformatf("got cyc=%0d a=%0d b=%0d k=%0d s=%0d sb=%0d sr=%0d, required cyc=%0d a=%0d b=%0d k=%0d s=%0d sb=%0d sr=%0d",
                        c, sn.ra, sn.rb, sn.tw, sn.stage, sn.sb, sn.sr,
                        e.cyc, e.a, e.b, e.k, e.s, e.m, e.r));
      end
    end else if (rd_q[u].size() > 0 && rd_q[u][0].cyc <= c) begin
      rd_exp_t e;
      e = rd_q[u].pop_front();
      check(1'b0, $sformatf("rd_missing_u%0d", u),
            $sformatf("got no read at cyc %0d, required a=%0d b=%0d k=%0d at cyc %0d", c, e.a, e.b, e.k, e.cyc));
    end

    if (sn.wr_en) begin
      if (wr_q[u].size() == 0) begin
        check(1'b0, $sformatf("wr_unexpected_u%0d", u),
              $sformatf("cyc %0d got write a=%0d b=%0d, required no write", c, sn.wa, sn.wb));
      end else begin
        wr_exp_t e;
        e = wr_q[u].pop_front();
        check(c == e.cyc && sn.wa == e.a && sn.wb == e.b, $sformatf("wr_u%0d", u),
              $sformatf("got cyc=%0d a=%0d b=%0d, required cyc=%0d a=%0d b=%0d",
                        c, sn.wa, sn.wb, e.cyc, e.a, e.b));
      end
    end else if (wr_q[u].size() > 0 && wr_q[u][0].cyc <= c) begin
      wr_exp_t e;
      e = wr_q[u].pop_front();
      check(1'b0, $sformatf("wr_missing_u%0d", u),
            $sformatf("got no write at cyc %0d, required a=%0d b=%0d at cyc %0d", c, e.a, e.b, e.cyc));
    end

    if (sn.done) begin
      if (done_q[u].size() == 0) begin
        check(1'b0, $sformatf("done_unexpected_u%0d", u),
              $sformatf("got done at cyc %0d, required none", c));
      end else begin
        int unsigned e;
        e = done_q[u].pop_front();
        check(c == e, $sformatf("done_u%0d", u),
              $sformatf("got done at cyc %0d, required cyc %0d", c, e));
      end
    end else if (done_q[u].size() > 0 && done_q[u][0] <= c) begin
      int unsigned e;
      e = done_q[u].pop_front();
      check(1'b0, $sformatf("done_missing_u%0d", u),
            $sformatf("got no done at cyc %0d, required at cyc %0d", c, e));
    end

    check(sn.busy == (c >= busy_lo[u] && c <= busy_hi[u]), $sformatf("busy_u%0d", u),
          $sformatf("cyc %0d got busy=%0d, required %0d", c, sn.busy,
                    (c >= busy_lo[u] && c <= busy_hi[u])));

    if (zero_chk_en && c == zero_chk_cyc)
      check(is_zero(sn), $sformatf("post_reset_zero_u%0d", u),
            $sformatf("cyc %0d got busy=%0d rd_en=%0d wr_en=%0d a=%0d stage=%0d, required all 0",
                      c, sn.busy, sn.rd_en, sn.wr_en, sn.ra, sn.stage));
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int u = 0; u < 2; u++) mon_unit(u);
    end
  end

  task automatic set_inputs(input int u, input bit st, input bit md, input bit rd);
    if (u == 0) begin
      if_big.start_i = st; if_big.mode_i = md; if_big.red_i = rd;
    end else begin
      if_sml.start_i = st; if_sml.mode_i = md; if_sml.red_i = rd;
    end
  endtask

  // One cycle of stimulus, applied at the negedge of cycle c
  task automatic drive_cycle(input int unsigned n);
    int unsigned c;
    c   = cyc;
    rst = 1'b0;
    if (!rst_done && runs[0] >= 1 && c == cur_t0[0] + 500 && c <= last_done[0]) begin
      rst         = 1'b1;
      rst_done    = 1'b1;
      zero_chk_cyc = c + 1;
      zero_chk_en = 1'b1;
      for (int u = 0; u < 2; u++) begin
        flush(u, c);
        set_inputs(u, 1'b1, 1'b1, 1'b1);
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        bit idle, st, md, rd;
        idle = (c > last_done[u]);
        if (u == 0) st = (n >= 2500 && n < 4500) ? 1'b1 : ($urandom_range(0, 1) == 0);
        else        st = ($urandom_range(0, 3) == 0);
        md = idle ? runs[u][0] : 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        set_inputs(u, st, md, rd);
        if (idle && st) model_run(u, c, md, rd);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    set_inputs(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      snap_t sn;
      sn = get_snap(u);
      check(is_zero(sn), $sformatf("reset_zero_u%0d", u),
            $sformatf("got busy=%0d done=%0d rd_en=%0d wr_en=%0d b=%0d, required all 0",
                      sn.busy, sn.done, sn.rd_en, sn.wr_en, sn.rb));
      last_done[u] = cyc - 1;
    end
    mon_en = 1'b1;
    for (int unsigned n = 0; n < 6000; n++) begin
      drive_cycle(n);
      @(negedge clk);
    end
    rst = 1'b0;
    set_inputs(0, 1'b0, 1'b0, 1'b0);
    set_inputs(1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3000; k++) begin
      if (rd_q[0].size() + wr_q[0].size() + done_q[0].size() +
          rd_q[1].size() + wr_q[1].size() + done_q[1].size() == 0) break;
      @(negedge clk);
    end
    for (int u = 0; u < 2; u++) begin
      check(rd_q[u].size() + wr_q[u].size() + done_q[u].size() == 0,
            $sformatf("drain_timeout_u%0d", u),
            $sformatf("got %0d reads, %0d writes, %0d done still outstanding, required 0",
                      rd_q[u].size(), wr_q[u].size(), done_q[u].size()));
    end
    check(runs[0] >= 4, "big_run_count",
          $sformatf("got %0d accepted runs, required at least 4", runs[0]));
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/ntt_ctrl.md
# ntt_ctrl

Sequencer for the shared `butterfly` unit that runs a complete in-place forward or inverse NTT over an N-coefficient polynomial held in a dual-port coefficient RAM. It issues one butterfly per cycle by generating RAM read addresses, twiddle-ROM addresses and the butterfly mode selects. It then writes the results back to the same addresses after the datapath latency, inserting drain bubbles between stages so no stage reads stale data.

## Interface
- `N_LOG2`, 8, log2 of transform size N (N = 256 default); legal 2..10
- `RD_LAT`, 1, read latency of coefficient RAM and twiddle ROM (cycles)
- `BF_LAT`, 1, register latency of the butterfly datapath (cycles); PIPE_LAT = RD_LAT + BF_LAT
- `clk_i` in 1 clock, all logic on rising edge
- `rst_i` in 1 synchronous active-high reset
- `start_i` in 1 start request, sampled only in IDLE
- `mode_i` in 1 0 = forward (CT), 1 = inverse (GS); latched at start
- `red_i` in 1 reduction select for the run; latched at start
- `busy_o` out 1 high from the cycle after start acceptance until done
- `done_o` out 1 one-cycle completion pulse
- `rd_en_o` out 1 read strobe for coefficient RAM and twiddle ROM
- `rd_addr_a_o` out N_LOG2 coefficient index a
- `rd_addr_b_o` out N_LOG2 coefficient index b = a + len
- `tw_addr_o` out N_LOG2 twiddle ROM index k
- `sel_butterfly_o` out 1 equals latched mode, to `butterfly.sel_butterfly_i`
- `sel_red_o` out 1 equals latched red, to `butterfly.sel_red_i`
- `wr_en_o` out 1 write strobe: `rd_en_o` delayed PIPE_LAT cycles
- `wr_addr_a_o` out N_LOG2 `rd_addr_a_o` delayed PIPE_LAT cycles
- `wr_addr_b_o` out N_LOG2 `rd_addr_b_o` delayed PIPE_LAT cycles
- `stage_o` out $clog2(N_LOG2)+1 current stage index s; 0 in IDLE

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: on `start_i`=1, latch mode and red, set s=0, i=0, and go to RUN.
- RUN: one butterfly per cycle, i = 0..N/2-1, with `rd_en_o`=1. After i = N/2-1, go to DRAIN.
- DRAIN: PIPE_LAT cycles with `rd_en_o`=0. Then either s<N_LOG2-1 (s++, i=0, RUN) or go to DONE.
- DONE: one cycle with `done_o`=1 and `busy_o`=0, then IDLE.
- Stage length:
  - forward: len = N >> (s+1)
  - inverse: len = 1 << s
- Address generation: g = i / len, o = i mod len, a = g·2·len + o, b = a + len. Use shifts and masks only, no dividers.
- Twiddle index:
  - forward: k = (1<<s) + g, so stage 0 uses k=1 and the last stage uses k=N/2..N-1
  - inverse: k = (N>>s) − 1 − g, so stage 0 uses k=N-1 down to N/2 and the last stage uses k=1
- `sel_butterfly_o` and `sel_red_o` are constant for the whole run.
- Write delay line: a PIPE_LAT-deep shift register carrying {en, a, b}. It shifts every cycle, including in DRAIN and DONE.
- Changes on `start_i`, `mode_i` or `red_i` while busy are ignored.
- No overlap: a new start is accepted at the earliest in the IDLE cycle after DONE.

## Timing
- Reset values:
  - all outputs are 0
  - the state is IDLE
  - the delay line is cleared, so no `wr_en_o` is issued after reset
- Reset mid-run: abort on the next edge. No further reads or writes are issued and there is no `done_o`.
- Start accepted at edge t0. In cycle t0+1: `busy_o`=1, `rd_en_o`=1, a=0, b=len(s=0).
- Each stage occupies N/2 + PIPE_LAT cycles.
- Stage s issues in cycles t0+1+s·(N/2+PIPE_LAT) through that + N/2−1.
- Write for an issue in cycle c appears in cycle c+PIPE_LAT.
- The last write lands in the final DRAIN cycle.
- `done_o` is high in cycle t0+1+N_LOG2·(N/2+PIPE_LAT). For the defaults this is t0+1041.
- `busy_o` falls in the same cycle `done_o` rises.
- `start_i` held high continuously: runs are back-to-back, with the next acceptance at the DONE+1 edge.

## Test plan
- Forward, defaults, start at t0:
  - cycle t0+1: a=0, b=128, k=1
  - cycle t0+128: a=127, b=255, k=1
  - first stage-1 issue at t0+131: a=0, b=64, k=2
  - `done_o` at t0+1041; exactly 1024 `wr_en_o` pulses
- Inverse, defaults:
  - stage 0 issues (0,1,k=255), (2,3,k=254), …, (254,255,k=128)
  - last stage issues (0,128,k=1) … (127,255,k=1)
  - `sel_butterfly_o`=1 throughout
- Golden end-to-end: RAM/ROM models plus `butterfly` with forward and inverse vectors from the text-file golden set. Final RAM contents must match the reference output; inverse∘forward returns the input (with the scaling stage as defined).
- Every write address pair equals the read pair issued exactly PIPE_LAT cycles earlier. No stage-s+1 read occurs before the final stage-s write.
- `rst_i` asserted at t0+500 for one cycle:
  - next cycle: all outputs 0 and no `wr_en_o`
  - a following start runs a full 1041-cycle sequence
- N_LOG2=3, RD_LAT=2, BF_LAT=0:
  - exhaustive pair/twiddle check for all 12 butterflies
  - `done_o` at t0+1+3·(4+2)=t0+19
  - `start_i` pulses while busy are ignored
